ex_stage: RTL

- Execute stage of the 5-stage MIPS pipeline. It sits directly downstream of the decode stage and consumes the decode-to-execute bus.
- Holds the ID/EX pipeline register, runs the ALU, and issues data-SRAM requests.
- Drives the forwarding bus and the load-use flag back to decode.
- Contains an iterative 32-cycle divider with HI/LO registers. The divider stalls the pipeline while it runs.

---
 rtl/ex_stage.sv | 313 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/ex_stage.sv
// ---------------------------------------------------------------------------
// ex_stage -- execute stage of the 5-stage MIPS pipeline.
//
// Holds the ID/EX pipeline register, evaluates the ALU, issues the data-SRAM
// request, feeds the forwarding bus and load-use flag back to decode, and
// (optionally) runs an iterative restoring divider with HI/LO registers.
//
// Optional feature macro: EX_DIV_EN
//   defined   : div/divu, HI/LO, mfhi/mflo and stallreq_for_ex are built.
//   undefined : div/divu are NOPs, mfhi/mflo return 0, stallreq_for_ex = 0,
//               and no divider or HI/LO state exists.
//
// Ports:
//   clk              clock
//   rst              synchronous, active-high reset
//   stall[5:0]       pipeline stall vector (1 = stop); [2] is this register,
//                    [3] is the downstream (EX/MEM) stage
//   id_to_ex_bus     decode bus {mem_op, pc, inst, alu_op, sel_src1,
//                    sel_src2, ram_en, ram_wen, rf_we, rf_waddr, sel_rf_res,
//                    rdata1, rdata2}
//   ex_to_mem_bus    {mem_op, pc, ram_en, ram_wen, sel_rf_res, rf_we,
//                    rf_waddr, ex_result}
//   ex_to_rf_bus     {rf_we, rf_waddr, ex_result} forwarding to decode
//   ex_ram_read      a load is sitting in EX (load-use detection)
//   stallreq_for_ex  divider busy request to the stall controller
//   data_sram_*      combinational data-SRAM request
// ---------------------------------------------------------------------------
module ex_stage #(
    parameter int ID_TO_EX_WD  = 164,
    parameter int EX_TO_MEM_WD = 81,
    parameter int DIV_CYCLES   = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [5:0]              stall,
    input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
    output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    output logic [37:0]             ex_to_rf_bus,
    output logic                    ex_ram_read,
    output logic                    stallreq_for_ex,
    output logic                    data_sram_en,
    output logic [3:0]              data_sram_wen,
    output logic [31:0]             data_sram_addr,
    output logic [31:0]             data_sram_wdata
);

    // ------------------------------------------------------------------
    // ID/EX pipeline register
    // ------------------------------------------------------------------
    logic [ID_TO_EX_WD-1:0] id_ex_q;
    logic                   id_ex_load;   // register takes a new value (instruction or bubble)

    assign id_ex_load = ~stall[2] | ~stall[3];

    always_ff @(posedge clk) begin
        if (rst) begin
            id_ex_q <= '0;
        end else if (stall[2] && !stall[3]) begin
            id_ex_q <= '0;                 // bubble: rf_we=0, ram_en=0
        end else if (!stall[2]) begin
            id_ex_q <= id_to_ex_bus;
        end
    end

    logic [4:0]  mem_op;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [11:0] alu_op;
    logic [2:0]  sel_src1;
    logic [3:0]  sel_src2;
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic        sel_rf_res;
    logic [31:0] rdata1;
    logic [31:0] rdata2;

    assign {mem_op, pc, inst, alu_op, sel_src1, sel_src2, ram_en, ram_wen,
            rf_we, rf_waddr, sel_rf_res, rdata1, rdata2} = id_ex_q;

    // ------------------------------------------------------------------
    // Instruction classification for the HI/LO path
    // ------------------------------------------------------------------
    logic [5:0] opcode;
    logic [5:0] func;
    logic       is_special;
    logic       is_mfhi;
    logic       is_mflo;

    assign opcode     = inst[31:26];
    assign func       = inst[5:0];
    assign is_special = (opcode == 6'h00);
    assign is_mfhi    = is_special && (func == 6'h10);
    assign is_mflo    = is_special && (func == 6'h12);

    // rs/rt/rd fields are consumed by decode; only imm/shamt/op/func matter here.
    logic unused_inst;
    assign unused_inst = ^inst[25:16];

    // ------------------------------------------------------------------
    // Operand selection (one-hot)
    // ------------------------------------------------------------------
    logic [31:0] imm_sext;
    logic [31:0] imm_zext;
    logic [31:0] shamt_zext;
    logic [31:0] src1;
    logic [31:0] src2;

    assign imm_sext   = {{16{inst[15]}}, inst[15:0]};
    assign imm_zext   = {16'h0000, inst[15:0]};
    assign shamt_zext = {27'd0, inst[10:6]};

    assign src1 = ({32{sel_src1[0]}} & rdata1)
                | ({32{sel_src1[1]}} & pc)
                | ({32{sel_src1[2]}} & shamt_zext);

    assign src2 = ({32{sel_src2[0]}} & rdata2)
                | ({32{sel_src2[1]}} & imm_sext)
                | ({32{sel_src2[2]}} & 32'd8)
                | ({32{sel_src2[3]}} & imm_zext);

    // ------------------------------------------------------------------
    // ALU; alu_op[11:0] = {add, sub, slt, sltu, and, nor, or, xor,
    //                      sll, srl, sra, lui}
    // ------------------------------------------------------------------
    logic [31:0] add_res;
    logic [31:0] sub_res;
    logic [31:0] slt_res;
    logic [31:0] sltu_res;
    logic [31:0] and_res;
    logic [31:0] nor_res;
    logic [31:0] or_res;
    logic [31:0] xor_res;
    logic [31:0] sll_res;
    logic [31:0] srl_res;
    logic [31:0] sra_res;
    logic [31:0] lui_res;
    logic [31:0] alu_res;
    logic [4:0]  sa;

    assign sa       = src1[4:0];
    assign add_res  = src1 + src2;
    assign sub_res  = src1 - src2;
    assign slt_res  = {31'd0, ($signed(src1) < $signed(src2))};
    assign sltu_res = {31'd0, (src1 < src2)};
    assign and_res  = src1 & src2;
    assign nor_res  = ~(src1 | src2);
    assign or_res   = src1 | src2;
    assign xor_res  = src1 ^ src2;
    assign sll_res  = src2 << sa;
    assign srl_res  = src2 >> sa;
    assign sra_res  = $unsigned($signed(src2) >>> sa);
    assign lui_res  = {src2[15:0], 16'h0000};

    assign alu_res = ({32{alu_op[11]}} & add_res)
                   | ({32{alu_op[10]}} & sub_res)
                   | ({32{alu_op[9]}}  & slt_res)
                   | ({32{alu_op[8]}}  & sltu_res)
                   | ({32{alu_op[7]}}  & and_res)
                   | ({32{alu_op[6]}}  & nor_res)
                   | ({32{alu_op[5]}}  & or_res)
                   | ({32{alu_op[4]}}  & xor_res)
                   | ({32{alu_op[3]}}  & sll_res)
                   | ({32{alu_op[2]}}  & srl_res)
                   | ({32{alu_op[1]}}  & sra_res)
                   | ({32{alu_op[0]}}  & lui_res);

    // HI/LO values seen by mfhi/mflo
    logic [31:0] hi_val;
    logic [31:0] lo_val;

`ifdef EX_DIV_EN
    // ------------------------------------------------------------------
    // Iterative restoring divider: IDLE -> RUN (DIV_CYCLES steps) -> DONE
    // ------------------------------------------------------------------
    localparam logic [1:0] DIV_IDLE = 2'd0;
    localparam logic [1:0] DIV_RUN  = 2'd1;
    localparam logic [1:0] DIV_DONE = 2'd2;
    localparam logic [5:0] DIV_LAST = 6'(DIV_CYCLES - 1);

    logic [1:0]  div_state;
    logic [5:0]  div_cnt;
    logic [31:0] div_quo;      // shifts the dividend out, quotient bits in
    logic [31:0] div_rem;
    logic [31:0] div_dsor;
    logic        div_neg_q;
    logic        div_neg_r;
    logic        div_by_zero;
    logic        div_done;     // current div already finished; blocks a restart while held
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic        is_div;
    logic        div_signed;
    logic        div_start;
    logic [31:0] abs_dend;
    logic [31:0] abs_dsor;
    logic [32:0] div_shift;
    logic [33:0] div_trial;
    logic [31:0] hi_new;
    logic [31:0] lo_new;

    assign is_div     = is_special && ((func == 6'h1A) || (func == 6'h1B));
    assign div_signed = ~func[0];
    assign div_start  = (div_state == DIV_IDLE) && is_div && !div_done;

    assign stallreq_for_ex = div_start || (div_state == DIV_RUN);

    assign abs_dend = (div_signed && rdata1[31]) ? (~rdata1 + 32'd1) : rdata1;
    assign abs_dsor = (div_signed && rdata2[31]) ? (~rdata2 + 32'd1) : rdata2;

    // One restoring step: shift in the next dividend bit, try a subtract.
    assign div_shift = {div_rem, div_quo[31]};
    assign div_trial = {1'b0, div_shift} - {2'b00, div_dsor};

    // A zero divisor leaves remainder = |dividend| after the loop, so the
    // regular sign fix-up already yields HI = dividend; only LO is forced.
    always_comb begin
        lo_new = div_neg_q ? (~div_quo + 32'd1) : div_quo;
        hi_new = div_neg_r ? (~div_rem + 32'd1) : div_rem;
        if (div_by_zero) begin
            lo_new = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_state   <= DIV_IDLE;
            div_cnt     <= '0;
            div_quo     <= '0;
            div_rem     <= '0;
            div_dsor    <= '0;
            div_neg_q   <= 1'b0;
            div_neg_r   <= 1'b0;
            div_by_zero <= 1'b0;
            div_done    <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
        end else begin
            case (div_state)
                DIV_IDLE: begin
                    if (div_start) begin
                        div_state   <= DIV_RUN;
                        div_cnt     <= '0;
                        div_quo     <= abs_dend;
                        div_rem     <= '0;
                        div_dsor    <= abs_dsor;
                        div_neg_q   <= div_signed && (rdata1[31] ^ rdata2[31]);
                        div_neg_r   <= div_signed && rdata1[31];
                        div_by_zero <= (rdata2 == 32'd0);
                    end
                end
                DIV_RUN: begin
                    div_quo <= {div_quo[30:0], ~div_trial[33]};
                    div_rem <= div_trial[33] ? div_shift[31:0] : div_trial[31:0];
                    div_cnt <= div_cnt + 6'd1;
                    if (div_cnt == DIV_LAST) begin
                        div_state <= DIV_DONE;
                    end
                end
                DIV_DONE: begin
                    hi_q      <= hi_new;
                    lo_q      <= lo_new;
                    div_state <= DIV_IDLE;
                end
                default: div_state <= DIV_IDLE;
            endcase

            if (id_ex_load) begin
                div_done <= 1'b0;
            end else if (div_state == DIV_DONE) begin
                div_done <= 1'b1;
            end
        end
    end

    // Forward a HI/LO write that completes this cycle.
    assign hi_val = (div_state == DIV_DONE) ? hi_new : hi_q;
    assign lo_val = (div_state == DIV_DONE) ? lo_new : lo_q;
`else
    localparam int UNUSED_DIV_CYCLES = DIV_CYCLES;

    assign stallreq_for_ex = 1'b0;
    assign hi_val          = '0;
    assign lo_val          = '0;
`endif

    // ------------------------------------------------------------------
    // Result selection and outputs
    // ------------------------------------------------------------------
    logic [31:0] ex_result;

    always_comb begin
        ex_result = alu_res;
        if (is_mfhi) begin
            ex_result = hi_val;
        end else if (is_mflo) begin
            ex_result = lo_val;
        end
    end

    assign ex_to_mem_bus = {mem_op, pc, ram_en, ram_wen, sel_rf_res,
                            rf_we, rf_waddr, ex_result};
    assign ex_to_rf_bus  = {rf_we, rf_waddr, ex_result};
    assign ex_ram_read   = ram_en & ~ram_wen[0];

    assign data_sram_en    = ram_en;
    assign data_sram_wen   = ram_wen[0] ? 4'hF : 4'h0;
    assign data_sram_addr  = ex_result;
    assign data_sram_wdata = rdata2;

endmodule
